// File: rtl/mux_seq_pkg.sv
// Shared types and helpers for the mux select sequencer.
//
// Contents:
//   seq_state_e   - sequencer FSM states (IDLE, SCAN)
//   NUM_CH        - number of mux data channels scanned
//   next_chan_t   - result of a "next enabled channel" search
//   next_chan()   - next set mask bit strictly above cur, with wrap flag
//   first_chan()  - lowest set mask bit
package mux_seq_pkg;

  typedef enum logic {
    IDLE,
    SCAN
  } seq_state_e;

  localparam int NUM_CH = 4;

  // valid = at least one channel enabled; wrap = the found channel is at or
  // below the current one, i.e. the scan has completed a full pass.
  typedef struct packed {
    logic       valid;
    logic       wrap;
    logic [1:0] chan;
  } next_chan_t;

  // Walks the candidate offsets from farthest to nearest so the nearest set
  // bit above cur wins. Offset NUM_CH lands back on cur itself, which covers
  // the single-enabled-channel case as a wrap.
  function automatic next_chan_t next_chan(input logic [NUM_CH-1:0] mask,
                                           input logic [1:0]        cur);
    next_chan_t res;
    logic [2:0] idx;
    res = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = {1'b0, cur} + 3'(i);
      if (mask[idx[1:0]]) begin
        res.valid = 1'b1;
        res.wrap  = idx[2];
        res.chan  = idx[1:0];
      end
    end
    return res;
  endfunction

  // Lowest set bit; returns 0 for an empty mask (callers gate on |mask).
  function automatic logic [1:0] first_chan(input logic [NUM_CH-1:0] mask);
    logic [1:0] res;
    res = 2'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        res = 2'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_dwell_counter.sv
// Dwell counter for the mux select sequencer.
//
// Counts clock cycles spent on the current channel and flags the last one.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, count returns to 0
//   clr  - synchronous clear to 0 (priority over en)
//   en   - increment enable
//   tc   - high while the count equals DWELL-1
module mux_dwell_counter #(
  parameter int CNT_W = 8,
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == LAST_CNT);

endmodule

// File: rtl/mux_select_sequencer.sv
// Sequencer driving the select (S2,S1) and enable (E) inputs of the 4:1 mux.
//
// Scans enabled channels in ascending order, holding each for DWELL cycles,
// in continuous or single-pass mode, and pulses pass_done at each pass end.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   start      - begin a scan when idle (ignored with an empty mask)
//   stop       - abort the scan; wins over start
//   single     - 1 = one pass then idle; captured together with start
//   chan_mask  - bit i enables channel i; sampled at start and at each advance
//   S1, S2     - registered channel select LSB / MSB
//   E          - registered mux enable, high while scanning
//   busy       - registered scan-in-progress flag
//   pass_done  - one-cycle pulse in the first cycle after a pass ends
module mux_select_sequencer
  import mux_seq_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        single,
  input  logic [3:0]  chan_mask,
  output logic        S1,
  output logic        S2,
  output logic        E,
  output logic        busy,
  output logic        pass_done
);

  seq_state_e state_q, state_d;
  logic [1:0] chan_q, chan_d;
  logic       single_q, single_d;
  logic       e_q, e_d;
  logic       busy_q, busy_d;
  logic       pass_done_q, pass_done_d;

  logic       cnt_clr;
  logic       cnt_en;
  logic       cnt_tc;
  next_chan_t nxt;

  mux_dwell_counter #(
    .CNT_W (CNT_W),
    .DWELL (DWELL)
  ) u_dwell (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  // Next-state logic. The counter is held at 0 while idle so a new scan
  // always starts at dwell count 0; at terminal count it is cleared on the
  // same edge the select moves, so channels are back-to-back with E high.
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    single_d    = single_q;
    e_d         = e_q;
    busy_d      = busy_q;
    pass_done_d = 1'b0;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    nxt         = next_chan(chan_mask, chan_q);

    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        e_d     = 1'b0;
        busy_d  = 1'b0;
        if (start && !stop && (chan_mask != 4'b0000)) begin
          state_d  = SCAN;
          chan_d   = first_chan(chan_mask);
          single_d = single;
          e_d      = 1'b1;
          busy_d   = 1'b1;
        end
      end

      SCAN: begin
        if (stop) begin
          state_d = IDLE;
          e_d     = 1'b0;
          busy_d  = 1'b0;
          cnt_clr = 1'b1;
        end else if (cnt_tc) begin
          cnt_clr = 1'b1;
          if (!nxt.valid) begin
            // Mask emptied during the scan: end it as a completed pass.
            state_d     = IDLE;
            e_d         = 1'b0;
            busy_d      = 1'b0;
            pass_done_d = 1'b1;
          end else if (nxt.wrap && single_q) begin
            // Select keeps its last channel while idle.
            state_d     = IDLE;
            e_d         = 1'b0;
            busy_d      = 1'b0;
            pass_done_d = 1'b1;
          end else begin
            chan_d      = nxt.chan;
            pass_done_d = nxt.wrap;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        e_d     = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // All FSM state and outputs are registered here; reset overrides
  // start and stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      chan_q      <= 2'd0;
      single_q    <= 1'b0;
      e_q         <= 1'b0;
      busy_q      <= 1'b0;
      pass_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      single_q    <= single_d;
      e_q         <= e_d;
      busy_q      <= busy_d;
      pass_done_q <= pass_done_d;
    end
  end

  assign S1        = chan_q[0];
  assign S2        = chan_q[1];
  assign E         = e_q;
  assign busy      = busy_q;
  assign pass_done = pass_done_q;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Self-checking bench for mux_select_sequencer: table-driven vectors,
// hand-written multi-cycle sequences and randomized stimulus compared
// against a cycle-level behavioural model of the scan rules.
module tb_mux_select_sequencer;

  localparam int DWELL = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       single;
  logic [3:0] chanMask;

  logic s1, s2, e, busy, passDone;
  logic s1Fast, s2Fast, eFast, busyFast, passDoneFast;

  int checks;
  int errors;

  // Behavioural model: remaining dwell cycles counted down per channel.
  logic       mActive;
  logic [1:0] mChan;
  logic       mPd;
  logic       mSingle;
  int         mLeft;

  mux_select_sequencer #(
    .DWELL (DWELL),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .single    (single),
    .chan_mask (chanMask),
    .S1        (s1),
    .S2        (s2),
    .E         (e),
    .busy      (busy),
    .pass_done (passDone)
  );

  // Second instance exercising the DWELL=1 boundary with the same inputs.
  mux_select_sequencer #(
    .DWELL (1),
    .CNT_W (8)
  ) dutFast (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .single    (single),
    .chan_mask (chanMask),
    .S1        (s1Fast),
    .S2        (s2Fast),
    .E         (eFast),
    .busy      (busyFast),
    .pass_done (passDoneFast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic       stop;
    logic       single;
    logic [3:0] mask;
    logic       expE;
    logic [1:0] expSel;
    logic       expPd;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mkVec(input logic r, input logic st, input logic sp,
                                 input logic sg, input logic [3:0] m,
                                 input logic ex, input logic [1:0] sel,
                                 input logic pd);
    vec_t v;
    v.rst = r; v.start = st; v.stop = sp; v.single = sg; v.mask = m;
    v.expE = ex; v.expSel = sel; v.expPd = pd;
    return v;
  endfunction

  // One clock of the reference model, applied with the inputs seen at the edge.
  task automatic modelStep(input logic r, input logic st, input logic sp,
                           input logic sg, input logic [3:0] m);
    int nxt;
    mPd = 1'b0;
    if (r) begin
      mActive = 1'b0; mChan = 2'd0; mSingle = 1'b0; mLeft = 0;
    end else if (!mActive) begin
      if (st && !sp && m != 4'b0000) begin
        mActive = 1'b1;
        mSingle = sg;
        mLeft   = DWELL;
        for (int c = 3; c >= 0; c--) if (m[c]) mChan = 2'(c);
      end
    end else if (sp) begin
      mActive = 1'b0;
    end else begin
      mLeft = mLeft - 1;
      if (mLeft == 0) begin
        nxt = -1;
        for (int k = 4; k >= 1; k--) if (m[(int'(mChan) + k) % 4]) nxt = int'(mChan) + k;
        if (nxt < 0) begin
          mActive = 1'b0;
          mPd     = 1'b1;
        end else begin
          if (nxt >= 4) mPd = 1'b1;
          if (nxt >= 4 && mSingle) begin
            mActive = 1'b0;
          end else begin
            mChan = 2'(nxt % 4);
            mLeft = DWELL;
          end
        end
      end
    end
  endtask

  task automatic checkValue(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic st, input logic sp,
                               input logic sg, input logic [3:0] m);
    rst = r; start = st; stop = sp; single = sg; chanMask = m;
    @(posedge clk);
    modelStep(r, st, sp, sg, m);
    #1;
  endtask

  task automatic checkOutput();
    checkValue("model_E",         {7'd0, e},        {7'd0, mActive});
    checkValue("model_busy",      {7'd0, busy},     {7'd0, mActive});
    checkValue("model_sel",       {6'd0, s2, s1},   {6'd0, mChan});
    checkValue("model_pass_done", {7'd0, passDone}, {7'd0, mPd});
  endtask

  task automatic tick(input logic r, input logic st, input logic sp,
                      input logic sg, input logic [3:0] m);
    applyStimulus(r, st, sp, sg, m);
    checkOutput();
  endtask

  task automatic expectDut(input string name, input logic ex, input logic [1:0] sel,
                           input logic pd);
    checkValue({name, "_E"},    {7'd0, e},        {7'd0, ex});
    checkValue({name, "_busy"}, {7'd0, busy},     {7'd0, ex});
    checkValue({name, "_sel"},  {6'd0, s2, s1},   {6'd0, sel});
    checkValue({name, "_pd"},   {7'd0, passDone}, {7'd0, pd});
  endtask

  initial begin
    checks = 0; errors = 0;
    mActive = 1'b0; mChan = 2'd0; mPd = 1'b0; mSingle = 1'b0; mLeft = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; single = 1'b0; chanMask = 4'b0000;

    // Reset, ignored starts, then a single pass over channels 1 and 3.
    vecs[0]  = mkVec(1, 0, 0, 0, 4'b0000, 0, 2'd0, 0);
    vecs[1]  = mkVec(0, 1, 0, 0, 4'b0000, 0, 2'd0, 0);
    vecs[2]  = mkVec(0, 1, 1, 0, 4'b1111, 0, 2'd0, 0);
    vecs[3]  = mkVec(0, 1, 0, 1, 4'b1010, 1, 2'd1, 0);
    vecs[4]  = mkVec(0, 0, 0, 0, 4'b1010, 1, 2'd1, 0);
    vecs[5]  = mkVec(0, 1, 0, 0, 4'b1010, 1, 2'd1, 0);
    vecs[6]  = mkVec(0, 0, 0, 0, 4'b1010, 1, 2'd1, 0);
    vecs[7]  = mkVec(0, 0, 0, 0, 4'b1010, 1, 2'd3, 0);
    vecs[8]  = mkVec(0, 0, 0, 0, 4'b1010, 1, 2'd3, 0);
    vecs[9]  = mkVec(0, 0, 0, 0, 4'b1010, 1, 2'd3, 0);
    vecs[10] = mkVec(0, 0, 0, 0, 4'b1010, 1, 2'd3, 0);
    vecs[11] = mkVec(0, 0, 0, 0, 4'b1010, 0, 2'd3, 1);
    vecs[12] = mkVec(0, 0, 0, 0, 4'b1010, 0, 2'd3, 0);
    vecs[13] = mkVec(0, 1, 0, 0, 4'b0100, 1, 2'd2, 0);
    vecs[14] = mkVec(1, 1, 1, 0, 4'b0100, 0, 2'd0, 0);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].single, vecs[i].mask);
      expectDut($sformatf("vec%0d", i), vecs[i].expE, vecs[i].expSel, vecs[i].expPd);
      checkOutput();
    end

    // Continuous scan over all channels: 4 cycles each, wrap in cycle 17.
    tick(0, 1, 0, 0, 4'b1111);
    expectDut("cont_c1", 1, 2'd0, 0);
    for (int k = 2; k <= 16; k++) begin
      tick(0, 0, 0, 0, 4'b1111);
      expectDut($sformatf("cont_c%0d", k), 1, 2'((k - 1) / DWELL), 0);
    end
    tick(0, 0, 0, 0, 4'b1111);
    expectDut("cont_wrap", 1, 2'd0, 1);
    tick(0, 0, 1, 0, 4'b1111);
    expectDut("cont_stop", 0, 2'd0, 0);

    // Stop in dwell cycle 2 of channel 2, then restart at the lowest channel.
    tick(0, 1, 0, 0, 4'b1111);
    for (int k = 2; k <= 10; k++) tick(0, 0, 0, 0, 4'b1111);
    expectDut("stop_pre", 1, 2'd2, 0);
    tick(0, 1, 1, 0, 4'b1111);
    expectDut("stop_post", 0, 2'd2, 0);
    tick(0, 1, 0, 0, 4'b1110);
    expectDut("restart_c1", 1, 2'd1, 0);
    for (int k = 2; k <= 4; k++) tick(0, 0, 0, 0, 4'b1110);
    expectDut("restart_c4", 1, 2'd1, 0);
    tick(0, 0, 0, 0, 4'b1110);
    expectDut("restart_adv", 1, 2'd2, 0);
    tick(0, 0, 1, 0, 4'b1110);

    // Mask bit of the active channel cleared mid-dwell, then mask emptied.
    tick(0, 1, 0, 0, 4'b1100);
    expectDut("mask_c1", 1, 2'd2, 0);
    for (int k = 2; k <= 4; k++) tick(0, 0, 0, 0, 4'b1000);
    expectDut("mask_c4", 1, 2'd2, 0);
    tick(0, 0, 0, 0, 4'b1000);
    expectDut("mask_adv", 1, 2'd3, 0);
    for (int k = 6; k <= 8; k++) tick(0, 0, 0, 0, 4'b0000);
    expectDut("mask_c8", 1, 2'd3, 0);
    tick(0, 0, 0, 0, 4'b0000);
    expectDut("mask_empty", 0, 2'd3, 1);

    // DWELL=1 instance advances every cycle.
    tick(1, 0, 0, 0, 4'b0000);
    tick(0, 1, 0, 0, 4'b1111);
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) tick(0, 0, 0, 0, 4'b1111);
      checkValue($sformatf("fast_sel%0d", k), {6'd0, s2Fast, s1Fast}, 8'(k % 4));
      checkValue($sformatf("fast_E%0d", k), {7'd0, eFast}, 8'd1);
      checkValue($sformatf("fast_busy%0d", k), {7'd0, busyFast}, 8'd1);
      checkValue($sformatf("fast_pd%0d", k), {7'd0, passDoneFast}, (k == 4) ? 8'd1 : 8'd0);
    end
    tick(0, 0, 1, 0, 4'b1111);

    // Randomized stimulus against the model.
    for (int n = 0; n < 3000; n++) begin
      tick($urandom_range(0, 127) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 40) == 0,
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b1011);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
